// File: rtl/auto_player_seq.sv
// Auto-play sequencer: walks a song memory of (note, duration, valid) entries and
// drives the buzzer key interface with each note, a silent gap, optional looping.
module auto_player_seq #(
   parameter int DEPTH      = 26,
   parameter int ADDR_W     = 5,
   parameter int NOTE_W     = 4,
   parameter int DUR_W      = 26,
   parameter int GAP_CYCLES = 50000000,
   parameter int CNT_W      = 28
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              pause,
   input  logic              loop_mode,
   input  logic [NOTE_W-1:0] note_value,
   input  logic [DUR_W-1:0]  duration_value,
   input  logic              isvalid,
   output logic              key_on,
   output logic [NOTE_W-1:0] key,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              playing,
   output logic              done
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_NOTE    = 3'd2,
      ST_GAP     = 3'd3,
      ST_ADVANCE = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam bit                HAS_GAP   = (GAP_CYCLES > 0);
   localparam logic [CNT_W-1:0]  GAP_LAST  = HAS_GAP ? CNT_W'(GAP_CYCLES - 1) : {CNT_W{1'b0}};

   // A zero duration still plays for one cycle, so the last count index is max(dur,1)-1.
   function automatic logic [CNT_W-1:0] note_last(input logic [DUR_W-1:0] dur);
      logic [CNT_W-1:0] ext;
      ext = CNT_W'(dur);
      if (ext == {CNT_W{1'b0}}) begin
         note_last = {CNT_W{1'b0}};
      end else begin
         note_last = ext - CNT_W'(1'b1);
      end
   endfunction

   state_t            state_r, state_s;
   logic [CNT_W-1:0]  cnt_r, cnt_s;
   logic [NOTE_W-1:0] note_r, note_s;
   logic [DUR_W-1:0]  dur_r, dur_s;
   logic [NOTE_W-1:0] key_r, key_s;
   logic [ADDR_W-1:0] addr_r, addr_s;
   logic              on_r, on_s;
   logic              playing_r, playing_s;
   logic              done_r, done_s;

   // Next-state, counter, address and output decode.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      note_s  = note_r;
      dur_s   = dur_r;
      key_s   = key_r;
      addr_s  = addr_r;
      if (stop) begin
         state_s = ST_IDLE;
         cnt_s   = {CNT_W{1'b0}};
         key_s   = {NOTE_W{1'b0}};
         addr_s  = {ADDR_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  state_s = ST_FETCH;
                  addr_s  = {ADDR_W{1'b0}};
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_FETCH: begin
               note_s = note_value;
               dur_s  = duration_value;
               if (isvalid) begin
                  state_s = ST_NOTE;
                  cnt_s   = {CNT_W{1'b0}};
                  key_s   = note_value;
               end else if (loop_mode && (addr_r != {ADDR_W{1'b0}})) begin
                  state_s = ST_FETCH;
                  addr_s  = {ADDR_W{1'b0}};
               end else begin
                  state_s = ST_DONE;
                  addr_s  = {ADDR_W{1'b0}};
                  key_s   = {NOTE_W{1'b0}};
               end
            end
            ST_NOTE: begin
               if (pause) begin
                  cnt_s = cnt_r;
               end else if (cnt_r == note_last(dur_r)) begin
                  cnt_s   = {CNT_W{1'b0}};
                  state_s = HAS_GAP ? ST_GAP : ST_ADVANCE;
               end else begin
                  cnt_s = cnt_r + CNT_W'(1'b1);
               end
            end
            ST_GAP: begin
               if (pause) begin
                  cnt_s = cnt_r;
               end else if (cnt_r == GAP_LAST) begin
                  cnt_s   = {CNT_W{1'b0}};
                  state_s = ST_ADVANCE;
               end else begin
                  cnt_s = cnt_r + CNT_W'(1'b1);
               end
            end
            ST_ADVANCE: begin
               if (addr_r != LAST_ADDR) begin
                  addr_s  = addr_r + ADDR_W'(1'b1);
                  state_s = ST_FETCH;
               end else if (loop_mode) begin
                  addr_s  = {ADDR_W{1'b0}};
                  state_s = ST_FETCH;
               end else begin
                  addr_s  = {ADDR_W{1'b0}};
                  key_s   = {NOTE_W{1'b0}};
                  state_s = ST_DONE;
               end
            end
            ST_DONE: begin
               state_s = ST_IDLE;
               cnt_s   = {CNT_W{1'b0}};
               key_s   = {NOTE_W{1'b0}};
               addr_s  = {ADDR_W{1'b0}};
            end
            default: begin
               state_s = ST_IDLE;
               cnt_s   = {CNT_W{1'b0}};
               key_s   = {NOTE_W{1'b0}};
               addr_s  = {ADDR_W{1'b0}};
            end
         endcase
      end
      on_s      = (state_s == ST_NOTE) && (note_s != {NOTE_W{1'b0}});
      playing_s = (state_s == ST_FETCH) || (state_s == ST_NOTE) ||
                  (state_s == ST_GAP)   || (state_s == ST_ADVANCE);
      done_s    = (state_s == ST_DONE);
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         cnt_r     <= {CNT_W{1'b0}};
         note_r    <= {NOTE_W{1'b0}};
         dur_r     <= {DUR_W{1'b0}};
         key_r     <= {NOTE_W{1'b0}};
         addr_r    <= {ADDR_W{1'b0}};
         on_r      <= 1'b0;
         playing_r <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         note_r    <= note_s;
         dur_r     <= dur_s;
         key_r     <= key_s;
         addr_r    <= addr_s;
         on_r      <= on_s;
         playing_r <= playing_s;
         done_r    <= done_s;
      end
   end

   // Pause gates the tone in the same cycle the counter freezes, so note-on time is preserved.
   assign key_on  = on_r & ~pause;
   assign key     = key_r;
   assign rd_addr = addr_r;
   assign playing = playing_r;
   assign done    = done_r;

endmodule

// File: tb/tb_auto_player_seq.sv
// Directed self-checking bench for auto_player_seq (DEPTH=4, GAP_CYCLES=3).
module tb_auto_player_seq;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 2;
   localparam int NOTE_W = 4;
   localparam int DUR_W  = 8;
   localparam int GAP    = 3;
   localparam int CNT_W  = 8;
   localparam int TMAX   = 64;

   logic              clk = 1'b0;
   logic              rst, start, stop, pause, loop_mode;
   logic [NOTE_W-1:0] note_value;
   logic [DUR_W-1:0]  duration_value;
   logic              isvalid;
   logic              key_on;
   logic [NOTE_W-1:0] key;
   logic [ADDR_W-1:0] rd_addr;
   logic              playing, done;

   logic [NOTE_W-1:0] mem_note [0:DEPTH-1];
   logic [DUR_W-1:0]  mem_dur  [0:DEPTH-1];
   logic              mem_v    [0:DEPTH-1];

   logic              tr_on   [0:TMAX-1];
   logic [NOTE_W-1:0] tr_key  [0:TMAX-1];
   logic [ADDR_W-1:0] tr_addr [0:TMAX-1];
   logic              tr_play [0:TMAX-1];
   logic              tr_done [0:TMAX-1];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign note_value     = mem_note[rd_addr];
   assign duration_value = mem_dur[rd_addr];
   assign isvalid        = mem_v[rd_addr];

   auto_player_seq #(
      .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOTE_W(NOTE_W),
      .DUR_W(DUR_W), .GAP_CYCLES(GAP), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
      .loop_mode(loop_mode), .note_value(note_value), .duration_value(duration_value),
      .isvalid(isvalid), .key_on(key_on), .key(key), .rd_addr(rd_addr),
      .playing(playing), .done(done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_entry(input int i, input int n, input int d, input bit v);
      mem_note[i] = NOTE_W'(n);
      mem_dur[i]  = DUR_W'(d);
      mem_v[i]    = v;
   endtask

   // Cycle 0 carries the start pulse; each cycle records outputs after inputs settle.
   task automatic run(input int n, input int p_from, input int p_len,
                      input int stop_at, input int rst_at, input int start2_at);
      for (int c = 0; c < n; c++) begin
         start = (c == 0) || (c == start2_at);
         pause = (c >= p_from) && (c < p_from + p_len);
         stop  = (c == stop_at);
         rst   = (c == rst_at);
         #1;
         tr_on[c]   = key_on;
         tr_key[c]  = key;
         tr_addr[c] = rd_addr;
         tr_play[c] = playing;
         tr_done[c] = done;
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      pause = 1'b0;
      stop  = 1'b0;
      rst   = 1'b0;
   endtask

   function automatic int sum_on(input int n);
      int s = 0;
      for (int i = 0; i < n; i++) s += (tr_on[i] === 1'b1) ? 1 : 0;
      return s;
   endfunction

   function automatic int sum_done(input int n);
      int s = 0;
      for (int i = 0; i < n; i++) s += (tr_done[i] === 1'b1) ? 1 : 0;
      return s;
   endfunction

   function automatic logic basic_on(input int c);
      return (c == 2) || (c == 3) || (c >= 9 && c <= 11) || (c == 17);
   endfunction

   function automatic int basic_key(input int c);
      return (c <= 3) ? 1 : (c <= 11) ? 2 : 3;
   endfunction

   task automatic load_basic();
      set_entry(0, 1, 2, 1'b1);
      set_entry(1, 2, 3, 1'b1);
      set_entry(2, 3, 1, 1'b1);
      set_entry(3, 0, 0, 1'b0);
   endtask

   task automatic check_basic(input string pfx);
      for (int c = 0; c < 26; c++) begin
         chk($sformatf("%s_on_c%0d", pfx, c), 32'(tr_on[c]), 32'(basic_on(c)));
         if (basic_on(c)) chk($sformatf("%s_key_c%0d", pfx, c), 32'(tr_key[c]), 32'(basic_key(c)));
      end
      chk({pfx, "_addr21"}, 32'(tr_addr[21]), 32'd2);
      chk({pfx, "_addr22"}, 32'(tr_addr[22]), 32'd3);
      chk({pfx, "_done22"}, 32'(tr_done[22]), 32'd0);
      chk({pfx, "_done23"}, 32'(tr_done[23]), 32'd1);
      chk({pfx, "_done24"}, 32'(tr_done[24]), 32'd0);
      chk({pfx, "_addr23"}, 32'(tr_addr[23]), 32'd0);
      chk({pfx, "_addr24"}, 32'(tr_addr[24]), 32'd0);
      chk({pfx, "_play1"},  32'(tr_play[1]),  32'd1);
      chk({pfx, "_play24"}, 32'(tr_play[24]), 32'd0);
      chk({pfx, "_ndone"},  32'(sum_done(26)), 32'd1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_mode = 1'b0;
      load_basic();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_key_on",  32'(key_on),  32'd0);
      chk("rst_key",     32'(key),     32'd0);
      chk("rst_rd_addr", 32'(rd_addr), 32'd0);
      chk("rst_playing", 32'(playing), 32'd0);
      chk("rst_done",    32'(done),    32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Basic single-shot playback.
      run(26, -1, 0, -1, -1, -1);
      check_basic("basic");

      // Start pulse during note 2 must not disturb anything.
      run(26, -1, 0, -1, -1, 10);
      check_basic("start_ign");

      // Four dur=1 notes, looping: a note every 6 cycles, wrap after addr 3.
      set_entry(0, 1, 1, 1'b1);
      set_entry(1, 2, 1, 1'b1);
      set_entry(2, 3, 1, 1'b1);
      set_entry(3, 4, 1, 1'b1);
      loop_mode = 1'b1;
      run(40, -1, 0, 38, -1, -1);
      for (int c = 0; c < 39; c++) begin
         chk($sformatf("loop_on_c%0d", c), 32'(tr_on[c]), 32'((c >= 2) && ((c - 2) % 6 == 0)));
         if ((c >= 2) && ((c - 2) % 6 == 0))
            chk($sformatf("loop_key_c%0d", c), 32'(tr_key[c]), 32'((((c - 2) / 6) % 4) + 1));
      end
      chk("loop_addr24", 32'(tr_addr[24]), 32'd3);
      chk("loop_addr25", 32'(tr_addr[25]), 32'd0);
      chk("loop_ndone",  32'(sum_done(40)), 32'd0);
      chk("loop_stop_play", 32'(tr_play[39]), 32'd0);
      chk("loop_stop_key",  32'(tr_key[39]),  32'd0);

      // Same memory, no loop: done right after addr 3's ADVANCE.
      loop_mode = 1'b0;
      run(28, -1, 0, -1, -1, -1);
      chk("once_non",    32'(sum_on(28)),  32'd4);
      chk("once_key20",  32'(tr_key[20]),  32'd4);
      chk("once_addr24", 32'(tr_addr[24]), 32'd3);
      chk("once_play24", 32'(tr_play[24]), 32'd1);
      chk("once_done24", 32'(tr_done[24]), 32'd0);
      chk("once_done25", 32'(tr_done[25]), 32'd1);
      chk("once_play25", 32'(tr_play[25]), 32'd0);
      chk("once_done26", 32'(tr_done[26]), 32'd0);

      // Loop with an end marker at addr 3: refetch addr 0 without a done pulse.
      load_basic();
      loop_mode = 1'b1;
      run(27, -1, 0, 25, -1, -1);
      chk("lmark_addr22", 32'(tr_addr[22]), 32'd3);
      chk("lmark_addr23", 32'(tr_addr[23]), 32'd0);
      chk("lmark_play23", 32'(tr_play[23]), 32'd1);
      chk("lmark_on23",   32'(tr_on[23]),   32'd0);
      chk("lmark_on24",   32'(tr_on[24]),   32'd1);
      chk("lmark_key24",  32'(tr_key[24]),  32'd1);
      chk("lmark_ndone",  32'(sum_done(27)), 32'd0);
      loop_mode = 1'b0;

      // Pause for 4 cycles from the 2nd NOTE cycle of a dur=5 note.
      set_entry(0, 5, 5, 1'b1);
      set_entry(1, 0, 0, 1'b0);
      set_entry(2, 0, 0, 1'b0);
      set_entry(3, 0, 0, 1'b0);
      run(20, 3, 4, -1, -1, -1);
      chk("pause_non", 32'(sum_on(20)), 32'd5);
      chk("pause_on2", 32'(tr_on[2]), 32'd1);
      for (int c = 3; c <= 6; c++) chk($sformatf("pause_off_c%0d", c), 32'(tr_on[c]), 32'd0);
      chk("pause_on7",    32'(tr_on[7]),    32'd1);
      chk("pause_on10",   32'(tr_on[10]),   32'd1);
      chk("pause_on11",   32'(tr_on[11]),   32'd0);
      chk("pause_key4",   32'(tr_key[4]),   32'd5);
      chk("pause_play4",  32'(tr_play[4]),  32'd1);
      chk("pause_done12", 32'(tr_done[12]), 32'd0);
      chk("pause_done15", 32'(tr_done[15]), 32'd0);
      chk("pause_done16", 32'(tr_done[16]), 32'd1);

      // Stop, then rst, in the GAP of note 2 together with a start pulse.
      load_basic();
      for (int k = 0; k < 2; k++) begin
         if (k == 0) run(16, -1, 0, 12, -1, 12);
         else        run(16, -1, 0, -1, 12, 12);
         chk($sformatf("abort%0d_key12", k),  32'(tr_key[12]),  32'd2);
         chk($sformatf("abort%0d_play12", k), 32'(tr_play[12]), 32'd1);
         chk($sformatf("abort%0d_on13", k),   32'(tr_on[13]),   32'd0);
         chk($sformatf("abort%0d_key13", k),  32'(tr_key[13]),  32'd0);
         chk($sformatf("abort%0d_addr13", k), 32'(tr_addr[13]), 32'd0);
         chk($sformatf("abort%0d_play13", k), 32'(tr_play[13]), 32'd0);
         chk($sformatf("abort%0d_done13", k), 32'(tr_done[13]), 32'd0);
         chk($sformatf("abort%0d_play15", k), 32'(tr_play[15]), 32'd0);
      end

      // dur=0 note plays one cycle; a rest keeps key_on low.
      set_entry(0, 7, 0, 1'b1);
      set_entry(1, 0, 2, 1'b1);
      set_entry(2, 0, 0, 1'b0);
      run(18, -1, 0, -1, -1, -1);
      chk("bnd_non",    32'(sum_on(18)),  32'd1);
      chk("bnd_on2",    32'(tr_on[2]),    32'd1);
      chk("bnd_key2",   32'(tr_key[2]),   32'd7);
      chk("bnd_on3",    32'(tr_on[3]),    32'd0);
      chk("bnd_addr8",  32'(tr_addr[8]),  32'd1);
      chk("bnd_on8",    32'(tr_on[8]),    32'd0);
      chk("bnd_key8",   32'(tr_key[8]),   32'd0);
      chk("bnd_play9",  32'(tr_play[9]),  32'd1);
      chk("bnd_done14", 32'(tr_done[14]), 32'd0);
      chk("bnd_done15", 32'(tr_done[15]), 32'd1);

      // Empty song (invalid at addr 0), even in loop mode: done 2 cycles after start.
      set_entry(0, 3, 3, 1'b0);
      loop_mode = 1'b1;
      run(5, -1, 0, -1, -1, -1);
      chk("empty_play1", 32'(tr_play[1]), 32'd1);
      chk("empty_done1", 32'(tr_done[1]), 32'd0);
      chk("empty_done2", 32'(tr_done[2]), 32'd1);
      chk("empty_play2", 32'(tr_play[2]), 32'd0);
      chk("empty_play3", 32'(tr_play[3]), 32'd0);
      chk("empty_non",   32'(sum_on(5)),  32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/auto_player_seq.md
Name: auto_player_seq

Overview:
Parameterised auto-play sequencer. It walks a song memory of (note, duration, valid) entries and drives the buzzer key interface with each note for its duration, followed by a fixed silent gap. Beyond single-shot playback it adds loop mode, pause/resume, sync-read memory support, zero-length handling and a done pulse. It sits between the song ROM/RAM and the buzzer tone generator, in the same slot as the existing auto-play block.

Parameters:
DEPTH, 26, song memory entries; addresses 0..DEPTH-1
ADDR_W, 5, address width; must satisfy 2^ADDR_W >= DEPTH
NOTE_W, 4, note code width; code 0 = rest
DUR_W, 26, duration width, in clk cycles
GAP_CYCLES, 50000000, silent cycles after each note; 0 = no gap
CNT_W, 28, internal counter width; must hold max(2^DUR_W-1, GAP_CYCLES)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
start  in  1  pulse; begins playback from address 0 when idle
stop  in  1  synchronous abort; same effect as rst on all outputs and state
pause  in  1  level; freezes playback while high
loop_mode  in  1  1 = restart at address 0 at end of song; 0 = stop
note_value  in  NOTE_W  memory note at rd_addr; valid one cycle after rd_addr changes
duration_value  in  DUR_W  memory duration at rd_addr; same timing as note_value
isvalid  in  1  memory entry-valid flag at rd_addr; 0 = end-of-song marker
key_on  out  1  buzzer enable
key  out  NOTE_W  note code to tone generator
rd_addr  out  ADDR_W  song memory read address
playing  out  1  high in FETCH/NOTE/GAP/ADVANCE
done  out  1  one-cycle pulse at end of a non-looping song

Behaviour:
- Reset: clk and rst as stated; rst is synchronous, active-high. On rst or stop, next cycle: state=IDLE, key_on=0, key=0, rd_addr=0, playing=0, done=0, counter=0. This also applies mid-note.
- Priority: rst > stop > start > pause.
- States: IDLE, FETCH, NOTE, GAP, ADVANCE, DONE.
- IDLE: outputs at reset values. start=1 -> FETCH, rd_addr=0. start is ignored in every other state.
- FETCH: lasts exactly 1 cycle. At its end, latch note_value, duration_value and isvalid into internal registers.
  - Latched isvalid=1 -> NOTE, counter=0.
  - Latched isvalid=0 with loop_mode=1 and rd_addr!=0 -> rd_addr=0, stay in FETCH.
  - Latched isvalid=0 otherwise (including an invalid entry at address 0, i.e. empty song) -> DONE.
  - key_on=0 during FETCH; key holds its previous value.
- NOTE: lasts max(dur,1) cycles, so dur=0 plays 1 cycle.
  - key=latched note.
  - key_on=1 unless latched note==0 (rest) or pause=1.
  - On the last cycle -> GAP (or ADVANCE if GAP_CYCLES=0), counter=0.
- GAP: lasts GAP_CYCLES cycles. key_on=0; key holds the note. Then -> ADVANCE.
- ADVANCE: lasts 1 cycle, key_on=0.
  - rd_addr != DEPTH-1: rd_addr+1 -> FETCH.
  - rd_addr == DEPTH-1 and loop_mode=1: rd_addr=0 -> FETCH.
  - rd_addr == DEPTH-1 and loop_mode=0: -> DONE.
- DONE: lasts 1 cycle. done=1, key_on=0, key=0, rd_addr=0 -> IDLE.
- Pause: while pause=1 in NOTE or GAP, the counter holds, the state holds and key_on=0. On release, the remaining cycles continue; total note-on cycles are unchanged. Pause in FETCH/ADVANCE takes effect from the next NOTE/GAP cycle.
- loop_mode is sampled only at the end decision points (FETCH end, ADVANCE at DEPTH-1).
- Per-note period: 1 + max(dur,1) + GAP_CYCLES + 1 cycles. First key_on=1 occurs 2 cycles after start is sampled.
- Counter compares use CNT_W unsigned arithmetic with no overflow; duration is zero-extended.

Test Plan:
(All with DEPTH=4, GAP_CYCLES=3.)
- Basic playback: mem = {(1,2,v),(2,3,v),(3,1,v),(-,-,inv)}, loop=0, start at cycle 0 -> key_on=1 with key=1 in cycles 2-3, key=2 in 9-11, key=3 in 17; rd_addr reaches 3 at cycle 22; done=1 at cycle 23; IDLE with rd_addr=0 at cycle 24.
- Wrap and loop: all 4 entries valid with dur=1, loop=1 -> after ADVANCE at addr 3, rd_addr=0 and the note-1 sequence repeats every 24 cycles; done is never asserted. Same memory with loop=0 -> done pulse after addr 3's ADVANCE.
- Pause mid-note: dur=5; pause high for 4 cycles from the 2nd NOTE cycle -> key_on low for those 4 cycles; total key_on cycles = 5; the note ends 4 cycles later than unpaused.
- Stop/reset mid-operation: assert stop in the GAP of note 2 -> next cycle key_on=0, key=0, rd_addr=0, playing=0. A start in the same cycle as stop is ignored. Repeat the check with rst.
- Boundaries: dur=0 entry -> key_on for exactly 1 cycle. note=0 entry -> key_on stays 0 for its duration. Invalid entry at address 0 -> done pulse 2 cycles after start, no key_on.
- start ignored while playing: pulse start during NOTE of note 2 -> the sequence is unaffected.
